// File: rtl/sbqm_pkg.sv
// Shared types and helpers for the bank queue manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } sbqm_state_t;

    // Default wait-time width and its saturation value ("closed" / overflow).
    localparam int WW_DEF = 5;
    localparam int WMAX   = (1 << WW_DEF) - 1;

    // Clamp the teller console value to the number of tellers that exist.
    function automatic int clamp_t(input int t, input int max_t);
        return (t > max_t) ? max_t : t;
    endfunction

endpackage

// File: rtl/sbqm_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: W cycles after the start cycle; done is high during the last step.
// Backpressure: none; start is ignored while busy, abort cancels immediately.
module seq_divider #(
    parameter int W  = 4,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quotient
);
    localparam int CNTW = $clog2(W + 1);

    // The dividend register shifts out its top bit each step and collects
    // quotient bits at the bottom, so it ends up holding the quotient.
    logic [W-1:0]    dvd_q;
    logic [DW-1:0]   dsr_q;
    logic [DW-1:0]   rem_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   rem_nxt;
    logic            qbit;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[W-1]};
        qbit    = (rem_sh >= {1'b0, dsr_q});
        rem_nxt = qbit ? DW'(rem_sh - {1'b0, dsr_q}) : DW'(rem_sh);
    end

    assign done     = busy && (cnt_q == CNTW'(1));
    assign quotient = dvd_q;

    // Step sequencer: load on start, W steps, abort wins over everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (start && !busy) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            cnt_q <= CNTW'(W);
            busy  <= 1'b1;
        end else if (busy) begin
            dvd_q <= {dvd_q[W-2:0], qbit};
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/sbqm_pipelined.sv
// Bank queue manager: counts customers from sensor edges, computes wait time.
// Latency: sensor rise to pcount 2 cycles; pcount/teller change to wvalid <= CW+4.
// Backpressure: none; wvalid drops while a new wait time is being computed.
module sbqm_pipelined
    import sbqm_pkg::*;
#(
    parameter int MAX_Q     = 7,
    parameter int MAX_T     = 3,
    parameter int SERVICE_T = 3,
    parameter int CW        = $clog2(MAX_Q + 1),
    parameter int TW        = $clog2(MAX_T + 1),
    parameter int WW        = WW_DEF
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          up_count,
    input  logic          down_count,
    input  logic [TW-1:0] tcount,
    output logic          empty_flag,
    output logic          full_flag,
    output logic [CW-1:0] pcount,
    output logic [WW-1:0] wcount,
    output logic          wvalid,
    output logic          err_flag
);
    localparam int NW   = CW + 1;
    localparam int WSAT = (WW == WW_DEF) ? WMAX : ((1 << WW) - 1);

    logic          up_q, up_prev, dn_q, dn_prev;
    logic          up_ev, dn_ev;
    logic [CW-1:0] pcount_nxt;
    logic          err_nxt;
    logic [TW-1:0] t_cl, t_key;

    sbqm_state_t   state;
    logic [CW-1:0] last_p, work_p;
    logic [TW-1:0] last_t, work_t;
    logic          spec_vld;
    logic [WW-1:0] spec_val;
    logic          snap_chg, work_chg;

    logic          div_start, div_abort, div_busy, div_done;
    logic [NW-1:0] n_calc, div_quo;
    int            prod;
    logic [WW-1:0] w_calc;

    assign up_ev = up_q && !up_prev;
    assign dn_ev = dn_q && !dn_prev;

    // With an empty queue the teller count is irrelevant, so it is keyed as 0
    // to avoid recomputing a wait time that is 0 either way.
    assign t_cl     = TW'(clamp_t(int'(tcount), MAX_T));
    assign t_key    = (pcount == '0) ? '0 : t_cl;
    assign snap_chg = (pcount != last_p) || (t_key != last_t);
    assign work_chg = (pcount != work_p) || (t_key != work_t);

    // Sensor sampling: one register stage plus the previous sample for edges.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            up_q    <= 1'b0;
            up_prev <= 1'b0;
            dn_q    <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_q    <= up_count;
            up_prev <= up_q;
            dn_q    <= down_count;
            dn_prev <= dn_q;
        end
    end

    // Next customer count and error; simultaneous arrival/departure cancel out.
    always_comb begin
        pcount_nxt = pcount;
        err_nxt    = err_flag;
        if (up_ev && !dn_ev) begin
            if (pcount == CW'(MAX_Q)) err_nxt = 1'b1;
            else                      pcount_nxt = pcount + CW'(1);
        end else if (dn_ev && !up_ev) begin
            if (pcount == '0) err_nxt = 1'b1;
            else              pcount_nxt = pcount - CW'(1);
        end
    end

    // Counter and flags, flags derived from the next count so they never lag.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pcount     <= '0;
            empty_flag <= 1'b1;
            full_flag  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            pcount     <= pcount_nxt;
            empty_flag <= (pcount_nxt == '0);
            full_flag  <= (pcount_nxt == CW'(MAX_Q));
            err_flag   <= err_nxt;
        end
    end

    // ceil(p/t) is computed as floor((p + t - 1) / t).
    assign n_calc    = NW'(int'(pcount) + int'(t_cl) - 1);
    assign div_start = (state == LOAD) && (pcount != '0) && (t_cl != '0);
    assign div_abort = (state == DIV) && work_chg;

    seq_divider #(
        .W  (NW),
        .DW (TW)
    ) u_div (
        .clk      (clk),
        .rst      (Reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (n_calc),
        .divisor  (t_cl),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Scale the quotient by service time and saturate to the output width.
    always_comb begin
        prod   = int'(div_quo) * SERVICE_T;
        w_calc = (prod > WSAT) ? WW'(WSAT) : WW'(prod);
    end

    // Wait-time sequencer: snapshot compare, divide, publish; restarts on change.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            last_p   <= '0;
            last_t   <= '0;
            work_p   <= '0;
            work_t   <= '0;
            spec_vld <= 1'b0;
            spec_val <= '0;
            wcount   <= '0;
            wvalid   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (snap_chg) begin
                        state  <= LOAD;
                        wvalid <= 1'b0;
                    end
                end
                LOAD: begin
                    work_p <= pcount;
                    work_t <= t_key;
                    if (pcount == '0) begin
                        spec_vld <= 1'b1;
                        spec_val <= '0;
                        state    <= DONE;
                    end else if (t_cl == '0) begin
                        spec_vld <= 1'b1;
                        spec_val <= WW'(WSAT);
                        state    <= DONE;
                    end else begin
                        spec_vld <= 1'b0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    if (work_chg || (!div_busy && !div_done)) state <= LOAD;
                    else if (div_done)                        state <= DONE;
                end
                DONE: begin
                    wcount <= spec_vld ? spec_val : w_calc;
                    last_p <= work_p;
                    last_t <= work_t;
                    // A change landing on this very cycle must not be flagged valid.
                    if (work_chg) begin
                        state <= LOAD;
                    end else begin
                        state  <= IDLE;
                        wvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbqm_pipelined.sv
// Directed bench for the bank queue manager: vector table plus corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_sbqm_pipelined;

    logic       clk;
    logic       Reset;
    logic       up_count;
    logic       down_count;
    logic [1:0] tcount;
    logic       empty_flag;
    logic       full_flag;
    logic [2:0] pcount;
    logic [4:0] wcount;
    logic       wvalid;
    logic       err_flag;

    int n_total;
    int n_pass;

    sbqm_pipelined dut (
        .clk        (clk),
        .Reset      (Reset),
        .up_count   (up_count),
        .down_count (down_count),
        .tcount     (tcount),
        .empty_flag (empty_flag),
        .full_flag  (full_flag),
        .pcount     (pcount),
        .wcount     (wcount),
        .wvalid     (wvalid),
        .err_flag   (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       up;
        logic       dn;
        logic [1:0] t;
        int         p;
        int         e;
        int         f;
        int         err;
        int         w;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic up, input logic dn, input logic [1:0] t,
                                input int p, input int e, input int f, input int err,
                                input int w);
        vec_t v;
        v.up = up; v.dn = dn; v.t = t;
        v.p = p; v.e = e; v.f = f; v.err = err; v.w = w;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Leaves the bench at posedge+1 with Reset released.
    task automatic do_reset();
        Reset = 1'b1;
        up_count = 1'b0;
        down_count = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
    endtask

    // One-cycle sensor pulse, called at posedge+1, returns at posedge+1.
    task automatic pulse(input logic u, input logic d);
        up_count = u;
        down_count = d;
        @(posedge clk);
        #1;
        up_count = 1'b0;
        down_count = 1'b0;
    endtask

    task automatic check_all(input string tag, input int p, input int e, input int f,
                             input int err, input int w, input int v);
        check({tag, " pcount"}, int'(pcount), p);
        check({tag, " empty_flag"}, int'(empty_flag), e);
        check({tag, " full_flag"}, int'(full_flag), f);
        check({tag, " err_flag"}, int'(err_flag), err);
        check({tag, " wcount"}, int'(wcount), w);
        check({tag, " wvalid"}, int'(wvalid), v);
    endtask

    task automatic wait_pcount(input int target, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(pcount) != target && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " pcount reached"}, int'(pcount), target);
    endtask

    initial begin
        int   n;
        logic glitch;
        logic first_wv;

        n_total = 0;
        n_pass  = 0;
        tcount  = 2'd0;

        // Reset state.
        do_reset();
        @(negedge clk);
        check_all("reset", 0, 1, 0, 0, 0, 1);

        // Five arrivals three cycles apart, then bounded wait for the wait time.
        @(posedge clk); #1;
        tcount = 2'd2;
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0);
            if (i < 4) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        wait_pcount(5, "lat");
        n = 0;
        while (!wvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lat wvalid", int'(wvalid), 1);
        check("lat cycles<=7", int'(n <= 7), 1);
        check("lat wcount", int'(wcount), 9);

        // Vector table: one event per row, then settle and compare everything.
        vecs[0]  = mk(1, 0, 2, 1, 0, 0, 0, 3);
        vecs[1]  = mk(1, 0, 2, 2, 0, 0, 0, 3);
        vecs[2]  = mk(1, 0, 2, 3, 0, 0, 0, 6);
        vecs[3]  = mk(1, 0, 2, 4, 0, 0, 0, 6);
        vecs[4]  = mk(1, 0, 2, 5, 0, 0, 0, 9);
        vecs[5]  = mk(1, 0, 2, 6, 0, 0, 0, 9);
        vecs[6]  = mk(1, 0, 2, 7, 0, 1, 0, 12);
        vecs[7]  = mk(1, 0, 2, 7, 0, 1, 1, 12);
        vecs[8]  = mk(0, 1, 2, 6, 0, 0, 1, 9);
        vecs[9]  = mk(1, 1, 3, 6, 0, 0, 1, 6);
        vecs[10] = mk(0, 0, 1, 6, 0, 0, 1, 18);
        vecs[11] = mk(0, 1, 1, 5, 0, 0, 1, 15);
        vecs[12] = mk(0, 0, 0, 5, 0, 0, 1, 31);
        vecs[13] = mk(0, 1, 3, 4, 0, 0, 1, 6);
        vecs[14] = mk(0, 1, 3, 3, 0, 0, 1, 3);
        vecs[15] = mk(0, 1, 3, 2, 0, 0, 1, 3);
        vecs[16] = mk(0, 1, 3, 1, 0, 0, 1, 3);
        vecs[17] = mk(0, 1, 3, 0, 1, 0, 1, 0);
        vecs[18] = mk(1, 1, 3, 0, 1, 0, 1, 0);
        vecs[19] = mk(1, 0, 0, 1, 0, 0, 1, 31);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            tcount = vecs[i].t;
            pulse(vecs[i].up, vecs[i].dn);
            repeat (14) @(posedge clk);
            @(negedge clk);
            check_all($sformatf("row%0d", i), vecs[i].p, vecs[i].e, vecs[i].f,
                      vecs[i].err, vecs[i].w, 1);
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a division clears outputs at once.
        tcount = 2'd3;
        pulse(1'b1, 1'b0);
        wait_pcount(2, "midrst");
        @(posedge clk);
        @(posedge clk);
        #3 Reset = 1'b1;
        #1;
        check_all("midrst", 0, 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        Reset = 1'b0;

        // Arrival and departure together at empty, then a rejected departure.
        do_reset();
        tcount = 2'd3;
        pulse(1'b1, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_all("both@empty", 0, 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        pulse(1'b0, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_all("dn@empty", 0, 1, 0, 1, 0, 1);

        // A level held high for ten cycles is a single arrival.
        do_reset();
        tcount = 2'd3;
        up_count = 1'b1;
        repeat (10) @(posedge clk);
        #1 up_count = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_all("hold", 1, 0, 0, 0, 3, 1);

        // Teller change in mid-division aborts and restarts the computation.
        do_reset();
        tcount = 2'd1;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (14) @(posedge clk);
        @(negedge clk);
        check_all("pre-abort", 3, 0, 0, 0, 9, 1);
        @(posedge clk); #1;
        pulse(1'b1, 1'b0);
        wait_pcount(4, "abort");
        repeat (3) @(posedge clk);
        #1 tcount = 2'd3;
        @(negedge clk);
        first_wv = wvalid;
        glitch = 1'b0;
        n = 1;
        while (!wvalid && n < 25) begin
            if (wcount != 5'd9) glitch = 1'b1;
            @(negedge clk);
            n++;
        end
        check("abort wvalid low", int'(first_wv), 0);
        check("abort no glitch", int'(glitch), 0);
        check("abort wvalid", int'(wvalid), 1);
        check("abort wcount", int'(wcount), 6);
        check("abort pcount", int'(pcount), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
